// File: rtl/nh_ctx_sched.sv
// Shares one nh_code_gen between CH_NUM channels: keeps per-channel NH context,
// round-robin arbitrates segment requests, loads/runs/saves the generator phase.
module nh_ctx_sched #(
  parameter int CH_NUM = 4,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [24:0]       cfg_code1,
  input  logic [19:0]       cfg_code2,
  input  logic [4:0]        cfg_len,
  input  logic [4:0]        cfg_count,
  input  logic [CH_NUM-1:0] req,
  input  logic              epoch_tick,
  input  logic              seg_done,
  output logic [CH_NUM-1:0] grant,
  output logic              busy,
  output logic [24:0]       nh_code1,
  output logic [19:0]       nh_code2,
  output logic [4:0]        nh_length,
  output logic              nh_increase,
  output logic              nh_count_en,
  output logic [4:0]        nh_count_i,
  input  logic [4:0]        nh_count_o
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, SAVE} state_t;

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   act_ch_reg;
  logic [CH_W-1:0]   rr_ptr_reg;
  logic              sticky_reg;
  logic [CH_NUM-1:0] grant_reg;
  logic [24:0]       code1_reg;
  logic [19:0]       code2_reg;
  logic [4:0]        length_reg;

  logic [24:0]       ctx_code1 [CH_NUM];
  logic [19:0]       ctx_code2 [CH_NUM];
  logic [4:0]        ctx_len   [CH_NUM];
  logic [4:0]        ctx_count [CH_NUM];

  logic [CH_NUM-1:0] cfg_hit;
  logic [CH_NUM-1:0] save_hit;
  logic [CH_NUM-1:0] act_onehot;
  logic              pick_valid;
  logic [CH_W-1:0]   pick_ch;
  logic [CH_W-1:0]   scan_idx;
  int                scan_sum;

  // Per-channel decode; an out-of-range cfg_ch matches no channel and is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign cfg_hit[gi]    = cfg_we && (cfg_ch == CH_W'(gi));
      assign act_onehot[gi] = (act_ch_reg == CH_W'(gi));
      assign save_hit[gi]   = (state_reg == SAVE) && !sticky_reg && act_onehot[gi];
    end
  endgenerate

  // Scan offsets high to low so the requester closest to rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_ch    = '0;
    scan_sum   = 0;
    scan_idx   = '0;
    for (int i = CH_NUM - 1; i >= 0; i--) begin
      scan_sum = int'(rr_ptr_reg) + i;
      if (scan_sum >= CH_NUM) scan_sum = scan_sum - CH_NUM;
      scan_idx = CH_W'(scan_sum);
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_ch    = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    nh_count_en = 1'b0;
    nh_count_i  = '0;
    nh_increase = 1'b0;
    case (state_reg)
      IDLE: if (pick_valid) state_next = LOAD;
      LOAD: begin
        nh_count_en = 1'b1;
        nh_count_i  = ctx_count[act_ch_reg];
        state_next  = RUN;
      end
      RUN: begin
        nh_increase = epoch_tick;
        if (seg_done) state_next = SAVE;
      end
      SAVE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_ch_reg <= '0;
      rr_ptr_reg <= '0;
      sticky_reg <= 1'b0;
      grant_reg  <= '0;
      code1_reg  <= '0;
      code2_reg  <= '0;
      length_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          sticky_reg <= 1'b0;
          if (pick_valid) begin
            act_ch_reg <= pick_ch;
            code1_reg  <= ctx_code1[pick_ch];
            code2_reg  <= ctx_code2[pick_ch];
            length_reg <= ctx_len[pick_ch];
          end
        end
        LOAD: grant_reg <= act_onehot;
        SAVE: begin
          grant_reg  <= '0;
          rr_ptr_reg <= (act_ch_reg == CH_W'(CH_NUM - 1)) ? '0 : act_ch_reg + 1'b1;
          code1_reg  <= '0;
          code2_reg  <= '0;
          length_reg <= '0;
        end
        default: ;
      endcase
      // A config write to the running channel owns its phase for this segment.
      if (state_reg != IDLE && cfg_we && cfg_ch == act_ch_reg) sticky_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CH_NUM; i++) begin
        ctx_code1[i] <= '0;
        ctx_code2[i] <= '0;
        ctx_len[i]   <= '0;
        ctx_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (cfg_hit[i]) begin
          ctx_code1[i] <= cfg_code1;
          ctx_code2[i] <= cfg_code2;
          ctx_len[i]   <= cfg_len;
          ctx_count[i] <= cfg_count;
        end else if (save_hit[i]) begin
          ctx_count[i] <= nh_count_o;
        end
      end
    end
  end

  assign grant     = grant_reg;
  assign busy      = (state_reg != IDLE);
  assign nh_code1  = code1_reg;
  assign nh_code2  = code2_reg;
  assign nh_length = length_reg;

endmodule

// File: tb/tb_nh_ctx_sched.sv
// Directed bench for nh_ctx_sched with a small behavioural stand-in for nh_code_gen.
module tb_nh_ctx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [24:0] cfg_code1;
  logic [19:0] cfg_code2;
  logic [4:0]  cfg_len;
  logic [4:0]  cfg_count;
  logic [3:0]  req;
  logic        epoch_tick;
  logic        seg_done;
  logic [3:0]  grant;
  logic        busy;
  logic [24:0] nh_code1;
  logic [19:0] nh_code2;
  logic [4:0]  nh_length;
  logic        nh_increase;
  logic        nh_count_en;
  logic [4:0]  nh_count_i;
  logic [4:0]  nh_count_o;

  logic [4:0]  gen_cnt;
  logic [5:0]  gen_inc;
  logic [24:0] t_c1 [4];
  logic [19:0] t_c2 [4];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  nh_ctx_sched #(.CH_NUM(4), .CH_W(2)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_code1(cfg_code1), .cfg_code2(cfg_code2),
    .cfg_len(cfg_len), .cfg_count(cfg_count),
    .req(req), .epoch_tick(epoch_tick), .seg_done(seg_done),
    .grant(grant), .busy(busy),
    .nh_code1(nh_code1), .nh_code2(nh_code2), .nh_length(nh_length),
    .nh_increase(nh_increase), .nh_count_en(nh_count_en),
    .nh_count_i(nh_count_i), .nh_count_o(nh_count_o)
  );

  // Generator stand-in: phase counts modulo length, load has priority.
  assign gen_inc = {1'b0, gen_cnt} + 6'd1;
  always_ff @(posedge clk) begin
    if (rst) gen_cnt <= '0;
    else if (nh_count_en) gen_cnt <= nh_count_i;
    else if (nh_increase && nh_length != 5'd0)
      gen_cnt <= (gen_inc >= {1'b0, nh_length}) ? 5'd0 : gen_inc[4:0];
  end
  assign nh_count_o = gen_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [24:0] c1, input logic [19:0] c2,
                     input logic [4:0] len, input logic [4:0] cnt);
    cfg_we = 1'b1; cfg_ch = ch; cfg_code1 = c1; cfg_code2 = c2; cfg_len = len; cfg_count = cnt;
    t_c1[ch] = c1;
    t_c2[ch] = c2;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic segment(input string tag, input logic [3:0] rq, input int ch,
                         input logic [4:0] ecnt, input logic [4:0] elen, input int ticks,
                         input bit with_done, input bit drop, input bit mid,
                         input logic [4:0] mid_len, input logic [4:0] mid_cnt);
    logic [3:0] g;
    g = 4'b0001 << ch;
    req = rq;
    step();
    chk({tag, ".load_en"},    32'(nh_count_en), 32'd1);
    chk({tag, ".load_cnt"},   32'(nh_count_i),  32'(ecnt));
    chk({tag, ".load_len"},   32'(nh_length),   32'(elen));
    chk({tag, ".load_code1"}, 32'(nh_code1),    32'(t_c1[ch]));
    chk({tag, ".load_code2"}, 32'(nh_code2),    32'(t_c2[ch]));
    chk({tag, ".load_grant"}, 32'(grant),       32'd0);
    if (drop) req = 4'b0000;
    step();
    chk({tag, ".run_grant"},  32'(grant),       32'(g));
    chk({tag, ".run_en"},     32'(nh_count_en), 32'd0);
    if (mid) begin
      cfg(2'(ch), t_c1[ch], t_c2[ch], mid_len, mid_cnt);
      chk({tag, ".len_hold"}, 32'(nh_length), 32'(elen));
    end
    for (int k = 0; k < ticks; k++) begin
      epoch_tick = 1'b1;
      if (with_done && k == ticks - 1) seg_done = 1'b1;
      #1;
      chk({tag, ".inc"}, 32'(nh_increase), 32'd1);
      step();
      epoch_tick = 1'b0;
    end
    if (!with_done || ticks == 0) begin
      seg_done = 1'b1;
      step();
    end
    seg_done = 1'b0;
    chk({tag, ".save_busy"},  32'(busy),  32'd1);
    chk({tag, ".save_grant"}, 32'(grant), 32'(g));
    epoch_tick = 1'b1;
    #1;
    chk({tag, ".save_noinc"}, 32'(nh_increase), 32'd0);
    epoch_tick = 1'b0;
    step();
    chk({tag, ".idle_busy"},  32'(busy),      32'd0);
    chk({tag, ".idle_grant"}, 32'(grant),     32'd0);
    chk({tag, ".idle_len"},   32'(nh_length), 32'd0);
    chk({tag, ".idle_code1"}, 32'(nh_code1),  32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_code1 = '0; cfg_code2 = '0;
    cfg_len = '0; cfg_count = '0; req = '0; epoch_tick = 1'b0; seg_done = 1'b0;
    for (int i = 0; i < 4; i++) begin t_c1[i] = '0; t_c2[i] = '0; end
    step();
    step();
    rst = 1'b0;
    chk("rst.grant",  32'(grant),       32'd0);
    chk("rst.busy",   32'(busy),        32'd0);
    chk("rst.code1",  32'(nh_code1),    32'd0);
    chk("rst.len",    32'(nh_length),   32'd0);
    chk("rst.en",     32'(nh_count_en), 32'd0);
    chk("rst.cnt_i",  32'(nh_count_i),  32'd0);

    // Stray tick/done while idle must do nothing.
    epoch_tick = 1'b1; seg_done = 1'b1;
    #1;
    chk("idle.noinc", 32'(nh_increase), 32'd0);
    step();
    chk("idle.busy",  32'(busy), 32'd0);
    epoch_tick = 1'b0; seg_done = 1'b0;

    cfg(2'd0, 25'h0000011, 20'h00022, 5'd10, 5'd0);
    cfg(2'd1, 25'h1ABCDEF, 20'hABCDE, 5'd20, 5'd3);
    cfg(2'd2, 25'h0123456, 20'h12345, 5'd5,  5'd4);
    cfg(2'd3, 25'h1FFFFFF, 20'hFFFFF, 5'd0,  5'd7);

    // 3 + 5 ticks = 8; then reload shows the saved phase.
    segment("t1",  4'b0010, 1, 5'd3,  5'd20, 5, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    segment("t1b", 4'b0010, 1, 5'd8,  5'd20, 0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    // Length 5 from phase 4: 4 -> 0 -> 1.
    segment("t2",  4'b0100, 2, 5'd4,  5'd5,  2, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    segment("t2b", 4'b0100, 2, 5'd1,  5'd5,  0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    // Last tick coincides with seg_done: 8 + 3 = 11.
    segment("t4",  4'b0010, 1, 5'd8,  5'd20, 3, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0);
    segment("t4b", 4'b0010, 1, 5'd11, 5'd20, 0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    // All request continuously; pointer is at 2 after ch1.
    segment("t3a", 4'b1111, 2, 5'd1,  5'd5,  0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    segment("t3b", 4'b1111, 3, 5'd7,  5'd0,  0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    segment("t3c", 4'b1111, 0, 5'd0,  5'd10, 0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    segment("t3d", 4'b1111, 1, 5'd11, 5'd20, 0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    segment("t3e", 4'b1111, 2, 5'd1,  5'd5,  0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    // Mid-run config to ch0 (count 10, len 12) beats the 2-tick write-back.
    segment("t5",  4'b0001, 0, 5'd0,  5'd10, 2, 1'b0, 1'b1, 1'b1, 5'd12, 5'd10);
    segment("t5b", 4'b0001, 0, 5'd10, 5'd12, 1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
    segment("t5c", 4'b0001, 0, 5'd11, 5'd12, 0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);

    // Reset in the middle of a ch2 segment.
    req = 4'b0100;
    step();
    step();
    chk("t6.grant_run", 32'(grant), 32'b0100);
    epoch_tick = 1'b1;
    step();
    epoch_tick = 1'b0;
    req = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6.grant", 32'(grant),       32'd0);
    chk("t6.busy",  32'(busy),        32'd0);
    chk("t6.len",   32'(nh_length),   32'd0);
    chk("t6.code1", 32'(nh_code1),    32'd0);
    chk("t6.en",    32'(nh_count_en), 32'd0);
    for (int i = 0; i < 4; i++) begin t_c1[i] = '0; t_c2[i] = '0; end
    segment("t6b", 4'b1111, 0, 5'd0, 5'd0, 0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
